csr_file: RTL and testbench
===========================

# csr_file

Machine-mode control and status register file for the single-cycle RV32I core. It sits directly downstream of the control unit and consumes its `csr_addr`, `csr_write_enable`, `csr_op` and `csr_imm` outputs. It returns the old CSR value for the rd write-back path and holds trap state plus the 64-bit cycle and instret counters. It also supplies `mtvec` and `mepc` to the next-PC logic for trap entry and `mret`.

## Interface
- `MTVEC_RESET`, default `32'h0000_0000`: reset value of `mtvec`.
- `HART_ID`, default `32'h0`: value returned by `mhartid`.

Ports:
- `clk` input 1: core clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `csr_addr` input 12: CSR address from the control unit.
- `csr_write_enable` input 1: CSR access request from the control unit.
- `csr_op` input 2: `00` = RW, `01` = RS, `10` = RC, `11` = immediate variant.
- `csr_funct3` input 3: `instruction[14:12]`; selects the immediate sub-operation.
- `csr_imm` input 5: uimm, zero-extended.
- `rs1_idx` input 5: `instruction[19:15]`.
- `rs1_data` input 32: register operand.
- `csr_rdata` output 32: old CSR value (combinational).
- `csr_illegal` output 1: access to an unimplemented CSR, or a write to a read-only CSR.
- `instr_retire` input 1: an instruction completes this cycle.
- `trap_valid` input 1: take a trap at this edge.
- `trap_cause` input 32: cause code.
- `trap_pc` input 32: faulting PC.
- `trap_val` input 32: `mtval` value.
- `mret_valid` input 1: an `mret` executes this cycle.
- `mtvec_out` output 32: trap target.
- `mepc_out` output 32: return target.
- `mie_global` output 1: `mstatus.MIE`.

## Operation
- Implemented CSRs and behaviour:
  - `mstatus` 0x300: writable bits are MIE[3] and MPIE[7]; MPP[12:11] is hardwired to `11`.
  - `misa` 0x301: read-only, `0x4000_0100`.
  - `mie` 0x304: writable bits are 3, 7 and 11.
  - `mtvec` 0x305: bits [1:0] forced to 0 (direct mode only).
  - `mscratch` 0x340: full read/write.
  - `mepc` 0x341: bits [1:0] forced to 0.
  - `mcause` 0x342 and `mtval` 0x343: full read/write.
  - `mip` 0x344: read-only, returns 0.
  - `mcycle`/`mcycleh` 0xB00/0xB80 and `minstret`/`minstreth` 0xB02/0xB82: read/write.
  - `cycle`/`cycleh`/`instret`/`instreth` 0xC00/0xC80/0xC02/0xC82: read-only shadows.
  - `mhartid` 0xF14: read-only, returns `HART_ID`.
- Source operand: `funct3[2]` ? `{27'b0, csr_imm}` : `rs1_data`.
- New value by `funct3[1:0]`:
  - `01`: src.
  - `10`: old | src.
  - `11`: old & ~src.
- A write happens only when all of these hold:
  - `csr_write_enable` is high;
  - the address is implemented and writable;
  - it is not the case that `funct3[1:0]` is not `01` and `rs1_idx` is 0. RS/RC/RSI/RCI with x0/uimm 0 perform no write, and accessing a read-only CSR that way is legal.
- `csr_illegal` = `csr_write_enable` & (the address is unimplemented, or a write is attempted to a read-only CSR). When it is asserted, no state changes. `csr_rdata` is 0 for unimplemented addresses.
- Trap entry (`trap_valid`):
  - `mepc` ← `trap_pc & ~3`;
  - `mcause` ← `trap_cause`;
  - `mtval` ← `trap_val`;
  - MPIE ← MIE, then MIE ← 0.
- `mret_valid`: MIE ← MPIE, MPIE ← 1.
- Priority within one cycle: trap > mret > CSR write.
- `mcycle` increments every cycle.
- `minstret` increments when `instr_retire` is high and `trap_valid` is low.
- Both counters are 64-bit and carry from the low word into the high word.
- A CSR write to either half of a counter replaces the increment for that whole counter in that cycle. The other half holds its value.

## Timing
- On reset:
  - `mstatus` = `0x0000_1800`;
  - `mtvec` = `MTVEC_RESET`;
  - `mepc`, `mcause`, `mtval`, `mscratch`, `mie` and both counters = 0;
  - outputs follow from these values; `mie_global` = 0.
- `csr_rdata`, `csr_illegal`, `mtvec_out`, `mepc_out` and `mie_global` are combinational from current state. The read returns the pre-write value within the same cycle.
- All state updates take effect at the rising edge of `clk`. Latency is 0 cycles for reads and 1 edge for writes.
- Reset asserted mid-operation restores the reset values immediately, with no clock needed.
- `mcycle` reads N in the Nth cycle after reset release, starting from 0.

## Structure
- Package `riscv_csr_pkg` holds:
  - CSR address constants;
  - `csr_op` and `funct3` encodings;
  - `mstatus` bit positions;
  - the `misa` constant;
  - `mcause` codes (ECALL = 11, illegal instruction = 2, breakpoint = 3).
- Sub-module `csr_counter64` (instantiated twice): 64-bit counter with an increment enable, low/high word write enables and 32-bit write data. Write overrides increment.

## Test plan
- Reset, then read 0x300, 0x301 and 0xF14 → `0x1800`, `0x4000_0100` and `HART_ID`; `mcycle` reads 5 five cycles after reset release.
- CSRRW 0x340 with `rs1_data` = `0xDEAD_BEEF` → `csr_rdata` = 0 that cycle. Then CSRRS x0 reads `0xDEAD_BEEF` with no write; then CSRRCI uimm = 0x0F leaves `0xDEAD_BEE0`.
- CSRRW 0x305 with `0x8000_0103` → `mtvec_out` = `0x8000_0100`. CSRRW 0xC00 → `csr_illegal` = 1, state unchanged. CSRRS 0xC00 x0 → legal, returns `mcycle`.
- Set MIE = 1, then pulse `trap_valid` (cause 11, pc `0x0000_0106`) → `mepc` = `0x104`, `mcause` = 11, MIE = 0, MPIE = 1. Then `mret_valid` → MIE = 1.
- Write `mcycle` = `0xFFFF_FFFF` → next cycle `mcycleh` = 1 and `mcycle` = 0. Simultaneous `instr_retire` + `trap_valid` → `minstret` unchanged.
- Same-cycle `trap_valid` and CSRRW to `mepc` → trap values win.

Source files
------------

// File: rtl/riscv_csr_pkg.sv
// Shared definitions for the machine-mode CSR file: addresses, operation
// encodings, mstatus field positions, fixed read-only values and cause codes.
package riscv_csr_pkg;

    // CSR addresses
    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    // csr_op encoding produced by the control unit
    typedef enum logic [1:0] {
        CSR_OP_RW  = 2'b00,
        CSR_OP_RS  = 2'b01,
        CSR_OP_RC  = 2'b10,
        CSR_OP_IMM = 2'b11
    } csr_op_e;

    // funct3[1:0] sub-operation and funct3[2] immediate select
    localparam logic [1:0] F3_RW      = 2'b01;
    localparam logic [1:0] F3_RS      = 2'b10;
    localparam logic [1:0] F3_RC      = 2'b11;
    localparam int         F3_IMM_BIT = 2;

    // mstatus fields
    localparam int         MSTATUS_MIE_BIT  = 3;
    localparam int         MSTATUS_MPIE_BIT = 7;
    localparam int         MSTATUS_MPP_LSB  = 11;
    localparam logic [1:0] MSTATUS_MPP_M    = 2'b11;

    // Fixed values and write masks
    localparam logic [31:0] MISA_VALUE = 32'h4000_0100;
    localparam logic [31:0] MIE_WMASK  = 32'h0000_0888;

    // mcause codes
    localparam logic [31:0] MCAUSE_ILLEGAL_INSTR = 32'd2;
    localparam logic [31:0] MCAUSE_BREAKPOINT    = 32'd3;
    localparam logic [31:0] MCAUSE_ECALL_M       = 32'd11;

    // Read-modify-write value for a CSR instruction; an unused encoding keeps the old value.
    function automatic logic [31:0] csr_alu(input logic [1:0] op,
                                            input logic [31:0] old_val,
                                            input logic [31:0] src);
        logic [31:0] res;
        res = old_val;
        case (op)
            F3_RW:   res = src;
            F3_RS:   res = old_val | src;
            F3_RC:   res = old_val & ~src;
            default: res = old_val;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/csr_file_if.sv
// CSR access bus between the control unit / datapath (master) and the CSR file (slave).
interface csr_file_if;
    logic [11:0]                 csr_addr;
    logic                        csr_write_enable;
    riscv_csr_pkg::csr_op_e      csr_op;
    logic [2:0]                  csr_funct3;
    logic [4:0]                  csr_imm;
    logic [4:0]                  rs1_idx;
    logic [31:0]                 rs1_data;
    logic [31:0]                 csr_rdata;
    logic                        csr_illegal;

    modport master (
        output csr_addr, csr_write_enable, csr_op, csr_funct3, csr_imm, rs1_idx, rs1_data,
        input  csr_rdata, csr_illegal
    );

    modport slave (
        input  csr_addr, csr_write_enable, csr_op, csr_funct3, csr_imm, rs1_idx, rs1_data,
        output csr_rdata, csr_illegal
    );
endinterface

// File: rtl/csr_counter64.sv
// 64-bit event counter with independent low/high word writes. A write to
// either word suppresses the increment for the whole counter that cycle.
module csr_counter64 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc_en,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wdata,
    output logic [63:0] count
);
    logic [63:0] cnt_reg;
    logic [63:0] cnt_next;

    // Next count: word write takes precedence over the increment
    always_comb begin
        cnt_next = cnt_reg;
        if (wr_lo) begin
            cnt_next[31:0] = wdata;
        end else if (wr_hi) begin
            cnt_next[63:32] = wdata;
        end else if (inc_en) begin
            cnt_next = cnt_reg + 64'd1;
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign count = cnt_reg;
endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file for the single-cycle RV32I core: read-modify-write
// CSR access, trap entry / mret state, and the cycle/instret counters.
module csr_file
    import riscv_csr_pkg::*;
#(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter logic [31:0] HART_ID     = 32'h0
) (
    input  logic              clk,
    input  logic              rst_n,
    csr_file_if.slave         bus,
    input  logic              instr_retire,
    input  logic              trap_valid,
    input  logic [31:0]       trap_cause,
    input  logic [31:0]       trap_pc,
    input  logic [31:0]       trap_val,
    input  logic              mret_valid,
    output logic [31:0]       mtvec_out,
    output logic [31:0]       mepc_out,
    output logic              mie_global
);
    logic        mstatus_mie_reg;
    logic        mstatus_mpie_reg;
    logic [31:0] mie_reg;
    logic [31:0] mtvec_reg;
    logic [31:0] mscratch_reg;
    logic [31:0] mepc_reg;
    logic [31:0] mcause_reg;
    logic [31:0] mtval_reg;

    // Index 0 is mcycle, index 1 is minstret
    logic [63:0] cnt_val   [2];
    logic        cnt_inc   [2];
    logic        cnt_wr_lo [2];
    logic        cnt_wr_hi [2];

    logic [31:0] mstatus_value;
    logic [31:0] old_value;
    logic        csr_impl;
    logic        csr_ro;
    logic [31:0] src_value;
    logic [31:0] new_value;
    logic        write_attempt;
    logic        csr_wr;

    // Assemble mstatus from its live bits; MPP is fixed at machine mode
    always_comb begin
        mstatus_value = '0;
        mstatus_value[MSTATUS_MPP_LSB +: 2] = MSTATUS_MPP_M;
        mstatus_value[MSTATUS_MPIE_BIT]     = mstatus_mpie_reg;
        mstatus_value[MSTATUS_MIE_BIT]      = mstatus_mie_reg;
    end

    // Address decode: old value, implemented and read-only flags
    always_comb begin
        old_value = '0;
        csr_impl  = 1'b1;
        csr_ro    = 1'b0;
        case (bus.csr_addr)
            CSR_MSTATUS:   old_value = mstatus_value;
            CSR_MISA:      begin old_value = MISA_VALUE; csr_ro = 1'b1; end
            CSR_MIE:       old_value = mie_reg;
            CSR_MTVEC:     old_value = mtvec_reg;
            CSR_MSCRATCH:  old_value = mscratch_reg;
            CSR_MEPC:      old_value = mepc_reg;
            CSR_MCAUSE:    old_value = mcause_reg;
            CSR_MTVAL:     old_value = mtval_reg;
            CSR_MIP:       begin old_value = '0; csr_ro = 1'b1; end
            CSR_MCYCLE:    old_value = cnt_val[0][31:0];
            CSR_MCYCLEH:   old_value = cnt_val[0][63:32];
            CSR_MINSTRET:  old_value = cnt_val[1][31:0];
            CSR_MINSTRETH: old_value = cnt_val[1][63:32];
            CSR_CYCLE:     begin old_value = cnt_val[0][31:0];  csr_ro = 1'b1; end
            CSR_CYCLEH:    begin old_value = cnt_val[0][63:32]; csr_ro = 1'b1; end
            CSR_INSTRET:   begin old_value = cnt_val[1][31:0];  csr_ro = 1'b1; end
            CSR_INSTRETH:  begin old_value = cnt_val[1][63:32]; csr_ro = 1'b1; end
            CSR_MHARTID:   begin old_value = HART_ID; csr_ro = 1'b1; end
            default:       csr_impl = 1'b0;
        endcase
    end

    // Operand select, new value, and the write / illegal decisions.
    // Set/clear with x0 (or uimm 0) is a pure read, so it is legal on read-only CSRs.
    // A trap or mret in the same cycle suppresses the CSR write entirely.
    always_comb begin
        src_value     = bus.csr_funct3[F3_IMM_BIT] ? {27'b0, bus.csr_imm} : bus.rs1_data;
        new_value     = csr_alu(bus.csr_funct3[1:0], old_value, src_value);
        write_attempt = (bus.csr_funct3[1:0] == F3_RW) ||
                        (((bus.csr_funct3[1:0] == F3_RS) || (bus.csr_funct3[1:0] == F3_RC)) &&
                         (bus.rs1_idx != 5'd0));
        csr_wr        = bus.csr_write_enable && csr_impl && !csr_ro && write_attempt &&
                        !trap_valid && !mret_valid;
    end

    assign bus.csr_rdata   = old_value;
    assign bus.csr_illegal = bus.csr_write_enable && (!csr_impl || (csr_ro && write_attempt));

    // Trap-related state: trap entry beats mret, which beats a CSR write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mstatus_mie_reg  <= 1'b0;
            mstatus_mpie_reg <= 1'b0;
            mie_reg          <= '0;
            mtvec_reg        <= MTVEC_RESET;
            mscratch_reg     <= '0;
            mepc_reg         <= '0;
            mcause_reg       <= '0;
            mtval_reg        <= '0;
        end else if (trap_valid) begin
            mepc_reg         <= trap_pc & ~32'h3;
            mcause_reg       <= trap_cause;
            mtval_reg        <= trap_val;
            mstatus_mpie_reg <= mstatus_mie_reg;
            mstatus_mie_reg  <= 1'b0;
        end else if (mret_valid) begin
            mstatus_mie_reg  <= mstatus_mpie_reg;
            mstatus_mpie_reg <= 1'b1;
        end else if (csr_wr) begin
            case (bus.csr_addr)
                CSR_MSTATUS: begin
                    mstatus_mie_reg  <= new_value[MSTATUS_MIE_BIT];
                    mstatus_mpie_reg <= new_value[MSTATUS_MPIE_BIT];
                end
                CSR_MIE:      mie_reg      <= new_value & MIE_WMASK;
                CSR_MTVEC:    mtvec_reg    <= new_value & ~32'h3;
                CSR_MSCRATCH: mscratch_reg <= new_value;
                CSR_MEPC:     mepc_reg     <= new_value & ~32'h3;
                CSR_MCAUSE:   mcause_reg   <= new_value;
                CSR_MTVAL:    mtval_reg    <= new_value;
                default:      ;
            endcase
        end
    end

    assign cnt_inc[0] = 1'b1;
    assign cnt_inc[1] = instr_retire && !trap_valid;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_counter
            localparam logic [11:0] LO_ADDR = (gi == 0) ? CSR_MCYCLE  : CSR_MINSTRET;
            localparam logic [11:0] HI_ADDR = (gi == 0) ? CSR_MCYCLEH : CSR_MINSTRETH;

            assign cnt_wr_lo[gi] = csr_wr && (bus.csr_addr == LO_ADDR);
            assign cnt_wr_hi[gi] = csr_wr && (bus.csr_addr == HI_ADDR);

            csr_counter64 u_counter (
                .clk    (clk),
                .rst_n  (rst_n),
                .inc_en (cnt_inc[gi]),
                .wr_lo  (cnt_wr_lo[gi]),
                .wr_hi  (cnt_wr_hi[gi]),
                .wdata  (new_value),
                .count  (cnt_val[gi])
            );
        end
    endgenerate

    assign mtvec_out  = mtvec_reg;
    assign mepc_out   = mepc_reg;
    assign mie_global = mstatus_mie_reg;
endmodule

// File: tb/tb_csr_file.sv
// Self-checking bench for csr_file: directed scenarios plus randomized
// traffic compared against a register-level reference model.
module tb_csr_file;
    import riscv_csr_pkg::*;

    localparam logic [31:0] MTVEC_RST = 32'h0000_1000;
    localparam logic [31:0] HART      = 32'h0000_0005;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_retire = 1'b0;
    logic        trap_valid = 1'b0;
    logic [31:0] trap_cause = '0;
    logic [31:0] trap_pc = '0;
    logic [31:0] trap_val = '0;
    logic        mret_valid = 1'b0;
    logic [31:0] mtvec_out;
    logic [31:0] mepc_out;
    logic        mie_global;

    int n_tests = 0;
    int n_fail  = 0;

    csr_file_if bus();

    csr_file #(.MTVEC_RESET(MTVEC_RST), .HART_ID(HART)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .instr_retire (instr_retire),
        .trap_valid   (trap_valid),
        .trap_cause   (trap_cause),
        .trap_pc      (trap_pc),
        .trap_val     (trap_val),
        .mret_valid   (mret_valid),
        .mtvec_out    (mtvec_out),
        .mepc_out     (mepc_out),
        .mie_global   (mie_global)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [31:0] m_mstatus, m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
    logic [63:0] m_cycle, m_instret;

    logic [11:0] addr_pool [0:21] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
                                     12'h342, 12'h343, 12'h344, 12'hB00, 12'hB80, 12'hB02,
                                     12'hB82, 12'hC00, 12'hC80, 12'hC02, 12'hC82, 12'hF14,
                                     12'h7C0, 12'h345, 12'hF11, 12'h306};
    logic [2:0] f3_pool [0:5] = '{3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b111};

    task automatic m_reset();
        m_mstatus = '0; m_mie = '0; m_mtvec = MTVEC_RST; m_mscratch = '0;
        m_mepc = '0; m_mcause = '0; m_mtval = '0; m_cycle = '0; m_instret = '0;
    endtask

    // 0 = unimplemented, 1 = read/write, 2 = read-only
    function automatic int m_kind(input logic [11:0] a);
        case (a)
            12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
            12'hB00, 12'hB80, 12'hB02, 12'hB82: return 1;
            12'h301, 12'h344, 12'hC00, 12'hC80, 12'hC02, 12'hC82, 12'hF14: return 2;
            default: return 0;
        endcase
    endfunction

    function automatic logic [31:0] m_read(input logic [11:0] a);
        case (a)
            12'h300: return m_mstatus | 32'h0000_1800;
            12'h301: return 32'h4000_0100;
            12'h304: return m_mie;
            12'h305: return m_mtvec;
            12'h340: return m_mscratch;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h343: return m_mtval;
            12'hB00, 12'hC00: return m_cycle[31:0];
            12'hB80, 12'hC80: return m_cycle[63:32];
            12'hB02, 12'hC02: return m_instret[31:0];
            12'hB82, 12'hC82: return m_instret[63:32];
            12'hF14: return HART;
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit m_attempt(input logic [2:0] f3, input logic [4:0] idx);
        return (f3[1:0] == 2'b01) || (f3[1:0] != 2'b00 && idx != 5'd0);
    endfunction

    function automatic bit m_illegal();
        int k;
        k = m_kind(bus.csr_addr);
        return bus.csr_write_enable && (k == 0 || (k == 2 && m_attempt(bus.csr_funct3, bus.rs1_idx)));
    endfunction

    // One clock edge of architectural behaviour, using the inputs currently driven
    task automatic m_step();
        logic [31:0] old_v, src, nv;
        logic [63:0] cyc_n, ins_n;
        bit wr;
        old_v = m_read(bus.csr_addr);
        src   = bus.csr_funct3[2] ? {27'b0, bus.csr_imm} : bus.rs1_data;
        case (bus.csr_funct3[1:0])
            2'b01:   nv = src;
            2'b10:   nv = old_v | src;
            2'b11:   nv = old_v & ~src;
            default: nv = old_v;
        endcase
        wr = bus.csr_write_enable && m_kind(bus.csr_addr) == 1 &&
             m_attempt(bus.csr_funct3, bus.rs1_idx) && !trap_valid && !mret_valid;
        cyc_n = m_cycle + 64'd1;
        ins_n = m_instret + ((instr_retire && !trap_valid) ? 64'd1 : 64'd0);
        if (trap_valid) begin
            m_mepc   = trap_pc & ~32'h3;
            m_mcause = trap_cause;
            m_mtval  = trap_val;
            m_mstatus = m_mstatus[3] ? 32'h80 : 32'h0;
        end else if (mret_valid) begin
            m_mstatus = m_mstatus[7] ? 32'h88 : 32'h80;
        end else if (wr) begin
            case (bus.csr_addr)
                12'h300: m_mstatus  = nv & 32'h88;
                12'h304: m_mie      = nv & 32'h888;
                12'h305: m_mtvec    = nv & ~32'h3;
                12'h340: m_mscratch = nv;
                12'h341: m_mepc     = nv & ~32'h3;
                12'h342: m_mcause   = nv;
                12'h343: m_mtval    = nv;
                12'hB00: cyc_n = {m_cycle[63:32], nv};
                12'hB80: cyc_n = {nv, m_cycle[31:0]};
                12'hB02: ins_n = {m_instret[63:32], nv};
                12'hB82: ins_n = {nv, m_instret[31:0]};
                default: ;
            endcase
        end
        m_cycle   = cyc_n;
        m_instret = ins_n;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic we, input logic [11:0] a, input logic [2:0] f3,
                         input logic [4:0] idx, input logic [31:0] d);
        bus.csr_write_enable = we;
        bus.csr_addr         = a;
        bus.csr_funct3       = f3;
        bus.rs1_idx          = idx;
        bus.csr_imm          = idx;
        bus.rs1_data         = d;
        bus.csr_op           = f3[2] ? CSR_OP_IMM : csr_op_e'(f3[1:0] - 2'd1);
    endtask

    // Advance one clock edge; inputs are driven on the falling edge
    task automatic tick();
        @(posedge clk);
        if (rst_n) m_step();
        @(negedge clk);
    endtask

    task automatic idle();
        drive(1'b0, 12'h300, 3'b010, 5'd0, 32'h0);
        instr_retire = 1'b0; trap_valid = 1'b0; mret_valid = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [31:0] exp_v;
        idle();
        m_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 12'h300, 3'b010, 5'd0, 32'h0);
        #1;
        n_tests++;
        if (bus.csr_rdata !== 32'h0000_1800) begin n_fail++; $display("FAIL reset_mstatus got %h exp %h", bus.csr_rdata, 32'h0000_1800); end
        n_tests++;
        if (mie_global !== 1'b0 || mtvec_out !== MTVEC_RST || mepc_out !== 32'h0) begin
            n_fail++; $display("FAIL reset_outputs got mie=%b mtvec=%h mepc=%h exp 0 %h 0", mie_global, mtvec_out, mepc_out, MTVEC_RST);
        end
        drive(1'b0, 12'h301, 3'b010, 5'd0, 32'h0);
        #1;
        n_tests++;
        if (bus.csr_rdata !== 32'h4000_0100) begin n_fail++; $display("FAIL reset_misa got %h exp %h", bus.csr_rdata, 32'h4000_0100); end
        drive(1'b0, 12'hF14, 3'b010, 5'd0, 32'h0);
        #1;
        n_tests++;
        if (bus.csr_rdata !== HART) begin n_fail++; $display("FAIL reset_mhartid got %h exp %h", bus.csr_rdata, HART); end
        drive(1'b0, 12'hB00, 3'b010, 5'd0, 32'h0);
        repeat (5) tick();
        #1;
        exp_v = 32'd5;
        n_tests++;
        if (bus.csr_rdata !== exp_v) begin n_fail++; $display("FAIL mcycle_after_5 got %0d exp %0d", bus.csr_rdata, exp_v); end
        $display("[TB] reset: mcycle after 5 cycles = %0d", bus.csr_rdata);
    endtask

    task automatic test_scratch_rw();
        drive(1'b1, 12'h340, 3'b001, 5'd5, 32'hDEAD_BEEF);
        #1;
        n_tests++;
        if (bus.csr_rdata !== 32'h0) begin n_fail++; $display("FAIL csrrw_old got %h exp %h", bus.csr_rdata, 32'h0); end
        tick();
        drive(1'b1, 12'h340, 3'b010, 5'd0, 32'hFFFF_FFFF);
        #1;
        n_tests++;
        if (bus.csr_rdata !== 32'hDEAD_BEEF || bus.csr_illegal !== 1'b0) begin
            n_fail++; $display("FAIL csrrs_x0 got %h ill=%b exp %h ill=0", bus.csr_rdata, bus.csr_illegal, 32'hDEAD_BEEF);
        end
        tick();
        drive(1'b1, 12'h340, 3'b111, 5'h0F, 32'h0);
        #1;
        n_tests++;
        if (bus.csr_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL csrrs_x0_nowrite got %h exp %h", bus.csr_rdata, 32'hDEAD_BEEF); end
        tick();
        drive(1'b0, 12'h340, 3'b010, 5'd0, 32'h0);
        #1;
        n_tests++;
        if (bus.csr_rdata !== 32'hDEAD_BEE0) begin n_fail++; $display("FAIL csrrci got %h exp %h", bus.csr_rdata, 32'hDEAD_BEE0); end
        $display("[TB] mscratch: after rw/rs/rci = %h", bus.csr_rdata);
    endtask

    task automatic test_mtvec_readonly();
        logic [31:0] cyc;
        drive(1'b1, 12'h305, 3'b001, 5'd3, 32'h8000_0103);
        tick();
        idle();
        #1;
        n_tests++;
        if (mtvec_out !== 32'h8000_0100) begin n_fail++; $display("FAIL mtvec_align got %h exp %h", mtvec_out, 32'h8000_0100); end
        drive(1'b1, 12'hC00, 3'b001, 5'd4, 32'h1234_5678);
        #1;
        n_tests++;
        if (bus.csr_illegal !== 1'b1) begin n_fail++; $display("FAIL cycle_write_illegal got %b exp 1", bus.csr_illegal); end
        tick();
        drive(1'b1, 12'hC00, 3'b010, 5'd0, 32'h0);
        #1;
        cyc = m_read(12'hB00);
        n_tests++;
        if (bus.csr_illegal !== 1'b0 || bus.csr_rdata !== cyc) begin
            n_fail++; $display("FAIL cycle_read_x0 got %h ill=%b exp %h ill=0", bus.csr_rdata, bus.csr_illegal, cyc);
        end
        tick();
        $display("[TB] mtvec=%h cycle=%h", mtvec_out, cyc);
    endtask

    task automatic test_trap_mret();
        drive(1'b1, 12'h300, 3'b110, 5'd8, 32'h0);
        tick();
        idle();
        #1;
        n_tests++;
        if (mie_global !== 1'b1) begin n_fail++; $display("FAIL set_mie got %b exp 1", mie_global); end
        trap_valid = 1'b1; trap_cause = 32'd11; trap_pc = 32'h0000_0106; trap_val = 32'h0000_0BAD;
        tick();
        idle();
        #1;
        n_tests++;
        if (mepc_out !== 32'h0000_0104 || mie_global !== 1'b0) begin
            n_fail++; $display("FAIL trap_entry got mepc=%h mie=%b exp 104 0", mepc_out, mie_global);
        end
        drive(1'b0, 12'h342, 3'b010, 5'd0, 32'h0);
        #1;
        n_tests++;
        if (bus.csr_rdata !== 32'd11) begin n_fail++; $display("FAIL trap_mcause got %h exp %h", bus.csr_rdata, 32'd11); end
        drive(1'b0, 12'h300, 3'b010, 5'd0, 32'h0);
        #1;
        n_tests++;
        if (bus.csr_rdata !== 32'h0000_1880) begin n_fail++; $display("FAIL trap_mstatus got %h exp %h", bus.csr_rdata, 32'h0000_1880); end
        mret_valid = 1'b1;
        tick();
        idle();
        #1;
        n_tests++;
        if (mie_global !== 1'b1 || bus.csr_rdata !== 32'h0000_1888) begin
            n_fail++; $display("FAIL mret got mie=%b mstatus=%h exp 1 %h", mie_global, bus.csr_rdata, 32'h0000_1888);
        end
        $display("[TB] trap/mret: mstatus=%h", bus.csr_rdata);
    endtask

    task automatic test_counters();
        logic [31:0] ins;
        drive(1'b1, 12'hB00, 3'b001, 5'd1, 32'hFFFF_FFFF);
        tick();
        idle();
        tick();
        drive(1'b0, 12'hB00, 3'b010, 5'd0, 32'h0);
        #1;
        n_tests++;
        if (bus.csr_rdata !== 32'h0) begin n_fail++; $display("FAIL mcycle_wrap got %h exp 0", bus.csr_rdata); end
        drive(1'b0, 12'hB80, 3'b010, 5'd0, 32'h0);
        #1;
        n_tests++;
        if (bus.csr_rdata !== 32'h1) begin n_fail++; $display("FAIL mcycleh_carry got %h exp 1", bus.csr_rdata); end
        drive(1'b0, 12'hB02, 3'b010, 5'd0, 32'h0);
        #1;
        ins = bus.csr_rdata;
        n_tests++;
        if (ins !== m_read(12'hB02)) begin n_fail++; $display("FAIL minstret_model got %h exp %h", ins, m_read(12'hB02)); end
        instr_retire = 1'b1; trap_valid = 1'b1; trap_pc = 32'h200; trap_cause = 32'd2;
        tick();
        trap_valid = 1'b0;
        #1;
        n_tests++;
        if (bus.csr_rdata !== ins) begin n_fail++; $display("FAIL minstret_trap got %h exp %h", bus.csr_rdata, ins); end
        tick();
        instr_retire = 1'b0;
        #1;
        n_tests++;
        if (bus.csr_rdata !== ins + 32'd1) begin n_fail++; $display("FAIL minstret_inc got %h exp %h", bus.csr_rdata, ins + 32'd1); end
        $display("[TB] counters: minstret=%h", bus.csr_rdata);
    endtask

    task automatic test_trap_vs_write();
        drive(1'b1, 12'h341, 3'b001, 5'd7, 32'h1234_5678);
        trap_valid = 1'b1; trap_pc = 32'hABC0_0007; trap_cause = 32'd3; trap_val = 32'h77;
        tick();
        idle();
        drive(1'b0, 12'h343, 3'b010, 5'd0, 32'h0);
        #1;
        n_tests++;
        if (mepc_out !== 32'hABC0_0004 || bus.csr_rdata !== 32'h77) begin
            n_fail++; $display("FAIL trap_beats_write got mepc=%h mtval=%h exp %h %h", mepc_out, bus.csr_rdata, 32'hABC0_0004, 32'h77);
        end
        $display("[TB] trap vs write: mepc=%h", mepc_out);
    endtask

    task automatic test_random();
        logic [11:0] a;
        logic [2:0]  f3;
        logic [4:0]  idx;
        int          nbad;
        nbad = 0;
        for (int i = 0; i < 400; i++) begin
            a   = addr_pool[$urandom_range(0, 21)];
            f3  = f3_pool[$urandom_range(0, 5)];
            idx = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            drive($urandom_range(0, 9) < 7, a, f3, idx, $urandom);
            trap_valid   = ($urandom_range(0, 19) == 0);
            mret_valid   = !trap_valid && ($urandom_range(0, 19) == 0);
            instr_retire = $urandom_range(0, 1) == 1;
            trap_cause   = $urandom; trap_pc = $urandom; trap_val = $urandom;
            #1;
            n_tests++;
            if (bus.csr_rdata !== m_read(a) || bus.csr_illegal !== m_illegal() ||
                mtvec_out !== m_mtvec || mepc_out !== m_mepc || mie_global !== m_mstatus[3]) begin
                n_fail++; nbad++;
                $display("FAIL random_%0d addr=%h got rd=%h ill=%b mtvec=%h mepc=%h mie=%b exp rd=%h ill=%b mtvec=%h mepc=%h mie=%b",
                         i, a, bus.csr_rdata, bus.csr_illegal, mtvec_out, mepc_out, mie_global,
                         m_read(a), m_illegal(), m_mtvec, m_mepc, m_mstatus[3]);
            end
            tick();
        end
        idle();
        $display("[TB] random: 400 transactions, %0d mismatched", nbad);
    endtask

    task automatic test_async_reset();
        drive(1'b0, 12'hB00, 3'b010, 5'd0, 32'h0);
        #2;
        rst_n = 1'b0;
        m_reset();
        #1;
        n_tests++;
        if (bus.csr_rdata !== 32'h0 || mepc_out !== 32'h0 || mtvec_out !== MTVEC_RST || mie_global !== 1'b0) begin
            n_fail++; $display("FAIL async_reset got mcycle=%h mepc=%h mtvec=%h mie=%b exp 0 0 %h 0",
                               bus.csr_rdata, mepc_out, mtvec_out, mie_global, MTVEC_RST);
        end
        #1;
        rst_n = 1'b1;
        tick();
        #1;
        n_tests++;
        if (bus.csr_rdata !== 32'd1) begin n_fail++; $display("FAIL mcycle_after_async got %0d exp 1", bus.csr_rdata); end
        $display("[TB] async reset: mcycle=%0d", bus.csr_rdata);
    endtask

    initial begin
        idle();
        test_reset();
        test_scratch_rw();
        test_mtvec_readonly();
        test_trap_mret();
        test_counters();
        test_trap_vs_write();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
